// File: rtl/bus_pkg.sv
// Shared definitions for the system bus arbiter: state encoding,
// master indices, the reserved slave id and a one-hot decode helper.
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_SLAVE = 2'd1,
        BUSY       = 2'd2,
        RELEASE    = 2'd3
    } state_e;

    localparam logic       MASTER_1     = 1'b0;
    localparam logic       MASTER_2     = 1'b1;
    localparam logic [1:0] SID_INVALID  = 2'd3;
    localparam int         NUM_SLAVES_C = 3;

    function automatic logic [NUM_SLAVES_C-1:0] sid_onehot(
        input logic [1:0] sid
    );
        logic [NUM_SLAVES_C-1:0] oh;
        oh = '0;
        case (sid)
            2'd0:    oh = 3'b001;
            2'd1:    oh = 3'b010;
            2'd2:    oh = 3'b100;
            default: oh = '0;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/bus_timeout_counter.sv
// Watchdog cycle counter for an active bus transfer; flags the last
// allowed cycle so the arbiter can force a release.
module bus_timeout_counter #(
    parameter int TIMEOUT_LEN = 4096,
    parameter int CNT_W       = 12
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == CNT_W'(TIMEOUT_LEN - 1));

endmodule

// File: rtl/sys_bus_arbiter.sv
// Round-robin arbiter sharing the serial system bus between two masters
// and three slaves, with a watchdog on hung transfers.
module sys_bus_arbiter
    import bus_pkg::*;
#(
    parameter int SLAVE_ID_W  = 2,
    parameter int NUM_SLAVES  = 3,
    parameter int TIMEOUT_LEN = 4096,
    parameter int CNT_W       = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  m1_request,
    input  logic [SLAVE_ID_W-1:0] m1_slave_id,
    input  logic                  m2_request,
    input  logic [SLAVE_ID_W-1:0] m2_slave_id,
    input  logic                  bus_done,
    input  logic [NUM_SLAVES-1:0] slave_ready,
    output logic                  m1_grant,
    output logic                  m2_grant,
    output logic                  bus_owner,
    output logic [NUM_SLAVES-1:0] slave_sel,
    output logic                  bus_busy,
    output logic                  timeout,
    output logic                  id_error
);

    state_e          state_q, state_d;
    logic            owner_q, owner_d;
    logic            last_q, last_d;
    logic [1:0]      sid_q, sid_d;
    logic            to_d, ierr_d;
    logic            win;
    logic [1:0]      wid;
    logic            own_req;
    logic            sid_ready;
    logic            expired;

    logic                  m1_grant_q, m2_grant_q, owner_out_q;
    logic [NUM_SLAVES-1:0] sel_q;
    logic                  busy_q, to_q, ierr_q;

    bus_timeout_counter #(
        .TIMEOUT_LEN (TIMEOUT_LEN),
        .CNT_W       (CNT_W)
    ) u_tmo (
        .clk       (clk),
        .reset     (reset),
        .clear_i   (state_q == IDLE),
        .enable_i  ((state_q == WAIT_SLAVE) || (state_q == BUSY)),
        .expired_o (expired)
    );

    assign own_req   = owner_q ? m2_request : m1_request;
    assign sid_ready = |(slave_ready & sid_onehot(sid_q));

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        sid_d   = sid_q;
        to_d    = 1'b0;
        ierr_d  = 1'b0;
        win     = 1'b0;
        wid     = '0;
        unique case (state_q)
            IDLE: begin
                if (m1_request || m2_request) begin
                    // On a tie the master not served last goes first
                    win     = (m1_request && m2_request) ? ~last_q
                                                         : m2_request;
                    wid     = win ? m2_slave_id : m1_slave_id;
                    owner_d = win;
                    sid_d   = wid;
                    if (wid == SID_INVALID) begin
                        ierr_d = 1'b1;
                        last_d = win;
                    end else begin
                        state_d = WAIT_SLAVE;
                    end
                end
            end
            WAIT_SLAVE: begin
                if (!own_req) begin
                    state_d = RELEASE;
                end else if (expired) begin
                    state_d = RELEASE;
                    to_d    = 1'b1;
                end else if (sid_ready) begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (bus_done || !own_req) begin
                    state_d = RELEASE;
                    last_d  = owner_q;
                end else if (expired) begin
                    state_d = RELEASE;
                    to_d    = 1'b1;
                end
            end
            RELEASE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            owner_q     <= MASTER_1;
            last_q      <= MASTER_2;
            sid_q       <= '0;
            m1_grant_q  <= 1'b0;
            m2_grant_q  <= 1'b0;
            owner_out_q <= 1'b0;
            sel_q       <= '0;
            busy_q      <= 1'b0;
            to_q        <= 1'b0;
            ierr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            sid_q       <= sid_d;
            m1_grant_q  <= (state_d == BUSY) && (owner_d == MASTER_1);
            m2_grant_q  <= (state_d == BUSY) && (owner_d == MASTER_2);
            owner_out_q <= (state_d == BUSY) && owner_d;
            sel_q       <= (state_d == BUSY) ? sid_onehot(sid_d) : '0;
            busy_q      <= (state_d != IDLE);
            to_q        <= to_d;
            ierr_q      <= ierr_d;
        end
    end

    assign m1_grant  = m1_grant_q;
    assign m2_grant  = m2_grant_q;
    assign bus_owner = owner_out_q;
    assign slave_sel = sel_q;
    assign bus_busy  = busy_q;
    assign timeout   = to_q;
    assign id_error  = ierr_q;

endmodule

// File: tb/tb_sys_bus_arbiter.sv
// Directed and randomized bench for sys_bus_arbiter against a
// transaction-level reference of the arbitration rules.
module tb_sys_bus_arbiter;

    localparam int TL = 32;

    logic       clk = 1'b0;
    logic       reset;
    logic       m1_request, m2_request, bus_done;
    logic [1:0] m1_slave_id, m2_slave_id;
    logic [2:0] slave_ready;
    logic       m1_grant, m2_grant, bus_owner, bus_busy, timeout, id_error;
    logic [2:0] slave_sel;

    int tests = 0;
    int fails = 0;

    // reference: current owner (-1 none), slave granted, release cycle
    int own  = -1;
    int gr   = 0;
    int rel  = 0;
    int last = 1;
    int age  = 0;
    int mid  = 0;
    int e_to = 0;
    int e_ie = 0;

    sys_bus_arbiter #(
        .SLAVE_ID_W  (2),
        .NUM_SLAVES  (3),
        .TIMEOUT_LEN (TL),
        .CNT_W       (5)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .m1_request  (m1_request),
        .m1_slave_id (m1_slave_id),
        .m2_request  (m2_request),
        .m2_slave_id (m2_slave_id),
        .bus_done    (bus_done),
        .slave_ready (slave_ready),
        .m1_grant    (m1_grant),
        .m2_grant    (m2_grant),
        .bus_owner   (bus_owner),
        .slave_sel   (slave_sel),
        .bus_busy    (bus_busy),
        .timeout     (timeout),
        .id_error    (id_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic end_transfer();
        own = -1;
        gr  = 0;
        rel = 1;
    endtask

    task automatic model_step();
        int r1, r2, w, wid_m, req_own;
        e_to = 0;
        e_ie = 0;
        r1 = int'(m1_request);
        r2 = int'(m2_request);
        if (reset) begin
            own = -1; gr = 0; rel = 0; last = 1; age = 0;
        end else if (rel != 0) begin
            rel = 0;
        end else if (own < 0) begin
            if (r1 + r2 > 0) begin
                w = (r1 + r2 == 2) ? 1 - last : (r2 != 0 ? 1 : 0);
                wid_m = (w == 1) ? int'(m2_slave_id) : int'(m1_slave_id);
                if (wid_m == 3) begin
                    e_ie = 1;
                    last = w;
                end else begin
                    own = w; mid = wid_m; gr = 0; age = 0;
                end
            end
        end else begin
            req_own = (own == 1) ? r2 : r1;
            if (gr != 0 && (bus_done || req_own == 0)) begin
                last = own;
                end_transfer();
            end else if (req_own == 0) begin
                end_transfer();
            end else if (age == TL - 1) begin
                e_to = 1;
                end_transfer();
            end else begin
                if (gr == 0 && slave_ready[mid]) gr = 1;
                age++;
            end
        end
    endtask

    task automatic compare_all();
        logic [7:0] expv, obsv;
        logic [2:0] esel;
        esel = (gr != 0) ? 3'(1 << mid) : 3'b000;
        expv = {(own == 0 && gr != 0), (own == 1 && gr != 0),
                (own >= 0 || rel != 0), (e_to != 0), (e_ie != 0), esel};
        obsv = {m1_grant, m2_grant, bus_busy, timeout, id_error, slave_sel};
        chk("outputs", 32'(obsv), 32'(expv));
        chk("mutex", 32'(m1_grant & m2_grant), 32'd0);
        if (gr != 0) chk("bus_owner", 32'(bus_owner), 32'(own));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    function automatic logic [1:0] rand_id();
        return ($urandom_range(0, 7) == 7) ? 2'd3 : 2'($urandom_range(0, 2));
    endfunction

    initial begin
        int pulses, pulse_at, grant_at_pulse;
        reset = 1'b1;
        m1_request = 0; m2_request = 0; bus_done = 0;
        m1_slave_id = 0; m2_slave_id = 0; slave_ready = 0;
        tick();
        tick();
        chk("reset_busy", 32'(bus_busy), 32'd0);
        reset = 1'b0;

        // single request
        m1_request = 1; m1_slave_id = 1; slave_ready = 3'b111;
        tick();
        chk("single_c1_nogrant", 32'(m1_grant), 32'd0);
        tick();
        chk("single_c2_grant", 32'(m1_grant), 32'd1);
        chk("single_c2_sel", 32'(slave_sel), 32'b010);
        repeat (8) tick();
        bus_done = 1; m1_request = 0;
        tick();
        bus_done = 0;
        chk("single_done_grant", 32'(m1_grant), 32'd0);
        chk("single_done_busy", 32'(bus_busy), 32'd1);
        tick();
        chk("single_idle_busy", 32'(bus_busy), 32'd0);

        // tie, round robin
        reset = 1; tick(); reset = 0;
        m1_request = 1; m1_slave_id = 0; m2_request = 1; m2_slave_id = 2;
        tick(); tick();
        chk("tie_first_m1", 32'(m1_grant), 32'd1);
        chk("tie_first_sel", 32'(slave_sel), 32'b001);
        bus_done = 1; m1_request = 0;
        tick();
        bus_done = 0;
        tick(); tick();
        chk("tie_k3_nogrant", 32'(m2_grant), 32'd0);
        tick();
        chk("tie_second_m2", 32'(m2_grant), 32'd1);
        chk("tie_second_sel", 32'(slave_sel), 32'b100);
        chk("tie_second_owner", 32'(bus_owner), 32'd1);
        bus_done = 1; m2_request = 0;
        tick();
        bus_done = 0;
        repeat (2) tick();

        // slave not ready
        m2_request = 1; m2_slave_id = 0; slave_ready = 3'b110;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("notready_busy", 32'(bus_busy), 32'd1);
            chk("notready_nogrant", 32'(m2_grant), 32'd0);
        end
        slave_ready = 3'b111;
        tick();
        chk("ready_grant", 32'(m2_grant), 32'd1);
        m2_request = 0;
        repeat (3) tick();

        // timeout without bus_done
        m1_request = 1; m1_slave_id = 2;
        pulses = 0; pulse_at = 0; grant_at_pulse = 1;
        for (int i = 1; i <= TL + 8; i++) begin
            tick();
            if (timeout) begin
                pulses++;
                pulse_at = i;
                grant_at_pulse = int'(m1_grant);
            end
        end
        chk("timeout_pulses", 32'(pulses), 32'd1);
        chk("timeout_cycle", 32'(pulse_at), 32'(TL + 1));
        chk("timeout_grant_low", 32'(grant_at_pulse), 32'd0);
        m1_request = 0;
        repeat (3) tick();

        // bus_done coinciding with expiry
        m1_request = 1;
        repeat (TL) tick();
        bus_done = 1;
        tick();
        bus_done = 0;
        chk("expiry_done_nopulse", 32'(timeout), 32'd0);
        chk("expiry_done_release", 32'(m1_grant), 32'd0);
        m1_request = 0;
        repeat (3) tick();

        // invalid id
        reset = 1; tick(); reset = 0;
        m1_request = 1; m1_slave_id = 3; m2_request = 1; m2_slave_id = 1;
        tick();
        chk("badid_pulse", 32'(id_error), 32'd1);
        chk("badid_nogrant", 32'(m1_grant | m2_grant), 32'd0);
        tick();
        chk("badid_single_pulse", 32'(id_error), 32'd0);
        tick();
        chk("badid_m2_next", 32'(m2_grant), 32'd1);
        m1_request = 0; m2_request = 0;
        repeat (3) tick();

        // reset mid-BUSY
        m1_request = 1; m1_slave_id = 0;
        tick(); tick();
        chk("rst_pre_grant", 32'(m1_grant), 32'd1);
        reset = 1;
        tick();
        chk("rst_outputs", 32'({m1_grant, m2_grant, bus_owner, slave_sel,
                                bus_busy, timeout, id_error}), 32'd0);
        reset = 0; m2_request = 1; m2_slave_id = 1;
        tick(); tick();
        chk("rst_tie_m1", 32'(m1_grant), 32'd1);
        m1_request = 0; m2_request = 0;
        repeat (3) tick();

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if (!m1_request) begin
                if ($urandom_range(0, 3) == 0) begin
                    m1_request = 1; m1_slave_id = rand_id();
                end
            end else if ($urandom_range(0, 11) == 0) begin
                m1_request = 0;
            end
            if (!m2_request) begin
                if ($urandom_range(0, 3) == 0) begin
                    m2_request = 1; m2_slave_id = rand_id();
                end
            end else if ($urandom_range(0, 11) == 0) begin
                m2_request = 0;
            end
            bus_done    = ($urandom_range(0, 3) == 0);
            slave_ready = 3'($urandom_range(0, 7) | $urandom_range(0, 7));
            reset       = ($urandom_range(0, 199) == 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
